// File: rtl/asl8_seq_pkg.sv
// Shared types and default sizing for the asl8_seq sequential left shifter.
package asl8_seq_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_SHAMT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/asl8_seq_if.sv
// Start/busy/done command and result bundle between a controller and asl8_seq.
interface asl8_seq_if
  import asl8_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
);

  logic               start;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d_out;
  logic               c_out;
  logic               ovf;
  logic               busy;
  logic               done;

  modport master (
    output start, d_in, shamt,
    input  d_out, c_out, ovf, busy, done
  );

  modport slave (
    input  start, d_in, shamt,
    output d_out, c_out, ovf, busy, done
  );

endinterface

// File: rtl/asl8_seq_step.sv
// Combinational single-bit left step: zero-filled shift, bit out, and MSB-change flag.
module asl8_seq_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             cy,
  output logic             sflip
);

  assign y     = {x[WIDTH-2:0], 1'b0};
  assign cy    = x[WIDTH-1];
  assign sflip = x[WIDTH-1] ^ x[WIDTH-2];

endmodule

// File: rtl/asl8_seq.sv
// Sequential arithmetic shift-left: one bit per clock, last-out carry and sticky signed overflow.
module asl8_seq
  import asl8_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic       clk,
  input  logic       reset,
  asl8_seq_if.slave  bus
);

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               ovf_w;

  logic [WIDTH-1:0]   d_out;
  logic               c_out;
  logic               ovf;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0]   step_y;
  logic               step_cy;
  logic               step_sflip;

  asl8_seq_step #(.WIDTH(WIDTH)) u_step (
    .x     (sreg),
    .y     (step_y),
    .cy    (step_cy),
    .sflip (step_sflip)
  );

  // FSM, down-counter and result registers; results load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      ovf_w <= 1'b0;
      d_out <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sreg  <= bus.d_in;
            cnt   <= bus.shamt;
            ovf_w <= 1'b0;
            busy  <= 1'b1;
            if (bus.shamt == SHAMT_W'(0)) begin
              state <= DONE;
              done  <= 1'b1;
              d_out <= bus.d_in;
              c_out <= 1'b0;
              ovf   <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sreg  <= step_y;
          ovf_w <= ovf_w | step_sflip;
          cnt   <= cnt - SHAMT_W'(1);
          // Final step: the shift still happens and its results go straight to the outputs.
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            d_out <= step_y;
            c_out <= step_cy;
            ovf   <= ovf_w | step_sflip;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d_out = d_out;
  assign bus.c_out = c_out;
  assign bus.ovf   = ovf;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_asl8_seq.sv
// Scoreboard bench for asl8_seq: directed and random shifts against an arithmetic model.
module tb_asl8_seq;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       o;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  asl8_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  asl8_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result of shifting d left by s: low byte of the wide product, bit 8 is the last bit out,
  // overflow iff the top s+1 bits of the operand are not all equal.
  function automatic exp_t model(input logic [7:0] d, input int s, input int now);
    exp_t        r;
    logic [15:0] wide;
    int          ones;
    wide  = 16'(d) << s;
    r.d   = wide[7:0];
    r.c   = (s == 0) ? 1'b0 : wide[8];
    ones  = 0;
    for (int i = 7 - s; i <= 7; i++) ones += int'(d[i]);
    r.o   = (ones != 0) && (ones != s + 1);
    r.cyc = now + s + 1;
    return r;
  endfunction

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("d_out", int'(bus.d_out), int'(e.d));
        chk("c_out", int'(bus.c_out), int'(e.c));
        chk("ovf",   int'(bus.ovf),   int'(e.o));
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic issue(input logic [7:0] d, input int s, input bit expect_done);
    wait_idle();
    bus.start = 1'b1;
    bus.d_in  = d;
    bus.shamt = 3'(s);
    if (expect_done) sbq.push_back(model(d, s, cyc));
    @(negedge clk);
    bus.start = 1'b0;
    bus.d_in  = 8'($urandom);
    bus.shamt = 3'($urandom);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.d_in  = '0;
    bus.shamt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_d_out", int'(bus.d_out), 0);
    chk("reset_c_out", int'(bus.c_out), 0);
    chk("reset_ovf",   int'(bus.ovf),   0);
    chk("reset_busy",  int'(bus.busy),  0);
    chk("reset_done",  int'(bus.done),  0);

    issue(8'b10101010, 1, 1'b1);
    issue(8'b00011000, 3, 1'b1);
    issue(8'b10101010, 0, 1'b1);
    issue(8'b11110000, 2, 1'b1);
    issue(8'h01,       7, 1'b1);

    // Start pulses during SHIFT must not disturb the op in flight.
    issue(8'b01000001, 7, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_in  = 8'hFF;
    bus.shamt = 3'd1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;

    // Reset mid-SHIFT aborts silently and clears all outputs.
    issue(8'hC3, 5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_d_out", int'(bus.d_out), 0);
    chk("abort_c_out", int'(bus.c_out), 0);
    chk("abort_ovf",   int'(bus.ovf),   0);
    chk("abort_busy",  int'(bus.busy),  0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), int'($urandom_range(0, 7)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("outstanding_results", sbq.size(), 0);
    @(negedge clk);
    chk("final_busy", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
